// File: rtl/sm83_pkg.sv
// Shared SM83 types: address select, interrupt FSM states,
// interrupt sources and the interrupt vector base.
package sm83_pkg;

    typedef logic [15:0] r16_t;

    typedef enum logic [2:0] {
        ADDR_NONE = 3'd0,
        ADDR_PC   = 3'd1,
        ADDR_SP   = 3'd2,
        ADDR_HL   = 3'd3,
        ADDR_IO   = 3'd4
    } addr_sel_t;

    typedef enum logic [2:0] {
        INT_IDLE      = 3'd0,
        INT_D_WAIT0   = 3'd1,
        INT_D_WAIT1   = 3'd2,
        INT_D_PUSH_HI = 3'd3,
        INT_D_PUSH_LO = 3'd4,
        INT_D_JUMP    = 3'd5
    } int_state_t;

    typedef enum logic [2:0] {
        INT_SRC_VBLANK = 3'd0,
        INT_SRC_STAT   = 3'd1,
        INT_SRC_TIMER  = 3'd2,
        INT_SRC_SERIAL = 3'd3,
        INT_SRC_JOYPAD = 3'd4
    } int_src_t;

    localparam r16_t INT_VEC_BASE = 16'h0040;

    function automatic r16_t int_vector(input logic [2:0] idx);
        return INT_VEC_BASE + {10'b0, idx, 3'b000};
    endfunction

endpackage

// File: rtl/sm83_int_prio.sv
// Lowest-set-bit encoder for pending interrupts.
// Ports: req_i[4:0] pending; idx_o lowest set index; vld_o any set.
module sm83_int_prio (
    input  logic [4:0] req_i,
    output logic [2:0] idx_o,
    output logic       vld_o
);

    always_comb begin
        idx_o = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (req_i[i]) idx_o = 3'(i);
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/sm83_int_ctl.sv
// SM83 interrupt controller: IF register, IME/EI delay, HALT and the
// 5 M-cycle dispatch (push PC, jump to vector).
// Ports: clk/rst_n (sync low), mcyc strobe, irq_in/IF access, ie,
// core ctl decodes + pc in; dispatch bus/SP/PC controls, ime, halted,
// halt_bug out. SM83_HALT_BUG_EN enables the halt_bug pulse.
module sm83_int_ctl
    import sm83_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mcyc,
    input  logic [4:0]  irq_in,
    input  logic        if_we,
    input  logic [4:0]  if_wdata,
    output logic [7:0]  if_rdata,
    input  logic [7:0]  ie,
    input  logic        instr_done,
    input  logic        ei_exec,
    input  logic        di_exec,
    input  logic        reti_exec,
    input  logic        halt_exec,
    input  logic [15:0] pc,
    output logic        dsp_active,
    output logic [2:0]  addr_sel,
    output logic        sp_dec,
    output logic        bus_wr,
    output logic [7:0]  bus_wdata,
    output logic        pc_load,
    output logic [15:0] pc_vec,
    output logic        ime,
    output logic        halted,
    output logic        halt_bug
);

    logic [4:0] if_q, if_d;
    logic       ime_q, ime_d;
    logic       ei_pend_q, ei_pend_d;
    logic       halted_q, halted_d;

    int_state_t state_q;
    addr_sel_t  addr_sel_q;
    logic       sp_dec_q, bus_wr_q, pc_load_q;
    logic [7:0] bus_wdata_q;
    r16_t       pc_vec_q;
    logic [2:0] idx_q;
    logic       idx_vld_q;

    logic [4:0] pending;
    logic [2:0] prio_idx;
    logic       prio_vld;
    logic       in_idle, ctl_ok, dsp_start;
    logic       unused_ie;

    assign unused_ie = &{1'b0, ie[7:5]};
    assign pending   = ie[4:0] & if_q;
    assign in_idle   = (state_q == INT_IDLE);
    assign ctl_ok    = instr_done && in_idle;
    assign dsp_start = ctl_ok && ime_q && (|pending);

    sm83_int_prio u_prio (
        .req_i (pending),
        .idx_o (prio_idx),
        .vld_o (prio_vld)
    );

    always_comb begin
        if_d      = if_q;
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        halted_d  = halted_q;
        if (if_we) if_d = if_wdata;
        if (state_q == INT_D_JUMP && idx_vld_q)
            if_d = if_d & ~(5'b00001 << idx_q);
        // a new request beats any clear in the same cycle
        if_d = if_d | irq_in;
        if (ctl_ok) begin
            if (ei_pend_q) begin
                ime_d     = 1'b1;
                ei_pend_d = 1'b0;
            end
            if (ei_exec)   ei_pend_d = 1'b1;
            if (reti_exec) ime_d = 1'b1;
            if (di_exec) begin
                ime_d     = 1'b0;
                ei_pend_d = 1'b0;
            end
        end
        if (dsp_start) ime_d = 1'b0;
        // HALT with something already pending never sleeps
        if (|pending)
            halted_d = 1'b0;
        else if (instr_done && halt_exec)
            halted_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_q      <= '0;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            halted_q  <= 1'b0;
        end else if (mcyc) begin
            if_q      <= if_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            halted_q  <= halted_d;
        end
    end

    // outputs are registered for the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INT_IDLE;
            addr_sel_q  <= ADDR_NONE;
            sp_dec_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_wdata_q <= 8'h00;
            pc_load_q   <= 1'b0;
            pc_vec_q    <= 16'h0000;
            idx_q       <= 3'd0;
            idx_vld_q   <= 1'b0;
        end else if (mcyc) begin
            addr_sel_q <= ADDR_NONE;
            sp_dec_q   <= 1'b0;
            bus_wr_q   <= 1'b0;
            pc_load_q  <= 1'b0;
            unique case (state_q)
                INT_IDLE: begin
                    if (dsp_start) state_q <= INT_D_WAIT0;
                end
                INT_D_WAIT0: begin
                    state_q  <= INT_D_WAIT1;
                    sp_dec_q <= 1'b1;
                end
                INT_D_WAIT1: begin
                    state_q     <= INT_D_PUSH_HI;
                    addr_sel_q  <= ADDR_SP;
                    bus_wr_q    <= 1'b1;
                    bus_wdata_q <= pc[15:8];
                    sp_dec_q    <= 1'b1;
                end
                INT_D_PUSH_HI: begin
                    state_q     <= INT_D_PUSH_LO;
                    addr_sel_q  <= ADDR_SP;
                    bus_wr_q    <= 1'b1;
                    bus_wdata_q <= pc[7:0];
                end
                INT_D_PUSH_LO: begin
                    // late sample: a request can still win here
                    state_q   <= INT_D_JUMP;
                    pc_load_q <= 1'b1;
                    pc_vec_q  <= prio_vld ? int_vector(prio_idx) : 16'h0000;
                    idx_q     <= prio_idx;
                    idx_vld_q <= prio_vld;
                end
                INT_D_JUMP: begin
                    state_q <= INT_IDLE;
                end
                default: state_q <= INT_IDLE;
            endcase
        end
    end

`ifdef SM83_HALT_BUG_EN
    logic halt_bug_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            halt_bug_q <= 1'b0;
        else if (mcyc)
            halt_bug_q <= instr_done && halt_exec && !ime_q && (|pending);
    end

    assign halt_bug = halt_bug_q;
`else
    assign halt_bug = 1'b0;
`endif

    assign if_rdata   = {3'b111, if_q};
    assign dsp_active = !in_idle;
    assign addr_sel   = addr_sel_q;
    assign sp_dec     = sp_dec_q;
    assign bus_wr     = bus_wr_q;
    assign bus_wdata  = bus_wdata_q;
    assign pc_load    = pc_load_q;
    assign pc_vec     = pc_vec_q;
    assign ime        = ime_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_sm83_int_ctl.sv
// Self-checking bench for sm83_int_ctl: directed scenarios plus
// randomized IF traffic and dispatch checked against a simple model.
module tb_sm83_int_ctl;
    import sm83_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mcyc;
    logic [4:0]  irq_in;
    logic        if_we;
    logic [4:0]  if_wdata;
    logic [7:0]  if_rdata;
    logic [7:0]  ie;
    logic        instr_done;
    logic        ei_exec, di_exec, reti_exec, halt_exec;
    logic [15:0] pc;
    logic        dsp_active;
    logic [2:0]  addr_sel;
    logic        sp_dec;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic        pc_load;
    logic [15:0] pc_vec;
    logic        ime;
    logic        halted;
    logic        halt_bug;

    int total  = 0;
    int passed = 0;

    sm83_int_ctl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mcyc       (mcyc),
        .irq_in     (irq_in),
        .if_we      (if_we),
        .if_wdata   (if_wdata),
        .if_rdata   (if_rdata),
        .ie         (ie),
        .instr_done (instr_done),
        .ei_exec    (ei_exec),
        .di_exec    (di_exec),
        .reti_exec  (reti_exec),
        .halt_exec  (halt_exec),
        .pc         (pc),
        .dsp_active (dsp_active),
        .addr_sel   (addr_sel),
        .sp_dec     (sp_dec),
        .bus_wr     (bus_wr),
        .bus_wdata  (bus_wdata),
        .pc_load    (pc_load),
        .pc_vec     (pc_vec),
        .ime        (ime),
        .halted     (halted),
        .halt_bug   (halt_bug)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic quiet();
        irq_in = 5'h00; if_we = 1'b0; if_wdata = 5'h00;
        instr_done = 1'b0; ei_exec = 1'b0; di_exec = 1'b0;
        reti_exec = 1'b0; halt_exec = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic boundary(input logic ei, input logic di,
                            input logic reti, input logic hlt);
        instr_done = 1'b1; ei_exec = ei; di_exec = di;
        reti_exec = reti; halt_exec = hlt;
        tick();
        quiet();
    endtask

    task automatic write_if(input logic [4:0] v);
        if_we = 1'b1; if_wdata = v;
        tick();
        quiet();
    endtask

    // Triggers a boundary and follows the whole dispatch.
    task automatic dispatch(input string tag, input logic [15:0] exp_vec,
                            input logic [4:0] exp_if);
        logic [7:0]  wr_q[$];
        logic [15:0] vec;
        int n, sps, badsel;
        vec = 16'hxxxx; n = 0; sps = 0; badsel = 0;
        instr_done = 1'b1;
        tick();
        quiet();
        chk({tag, "_ime_clr"}, ime, 1'b0);
        while (dsp_active && n < 12) begin
            if (bus_wr) begin
                wr_q.push_back(bus_wdata);
                if (addr_sel != ADDR_SP) badsel++;
            end
            if (sp_dec) sps++;
            if (pc_load) vec = pc_vec;
            n++;
            tick();
        end
        chk({tag, "_cycles"}, n, 5);
        chk({tag, "_nwr"}, wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk({tag, "_hi"}, wr_q[0], pc[15:8]);
            chk({tag, "_lo"}, wr_q[1], pc[7:0]);
        end
        chk({tag, "_sel"}, badsel, 0);
        chk({tag, "_spdec"}, sps, 2);
        chk({tag, "_vec"}, vec, exp_vec);
        chk({tag, "_if"}, if_rdata, {3'b111, exp_if});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] m_if, w, low;
        logic       exp_hb;
        int         p;

        rst_n = 1'b0; mcyc = 1'b1; ie = 8'h00; pc = 16'h0000;
        quiet();
        do_reset();

        chk("rst_if", if_rdata, 8'hE0);
        chk("rst_ime", ime, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_dsp", dsp_active, 1'b0);
        chk("rst_strobes", {bus_wr, sp_dec, pc_load, halt_bug}, 4'b0);
        chk("rst_sel", addr_sel, ADDR_NONE);
        chk("rst_wdata", bus_wdata, 8'h00);
        chk("rst_vec", pc_vec, 16'h0000);

        // basic vblank dispatch
        ie = 8'h01; pc = 16'h1234;
        boundary(0, 0, 1, 0);
        chk("reti_ime", ime, 1'b1);
        irq_in = 5'h01; tick(); quiet();
        chk("irq_set", if_rdata, 8'hE1);
        dispatch("vbl", 16'h0040, 5'h00);

        // priority with several pending
        ie = 8'h1F; pc = 16'hBEEF;
        write_if(5'h14);
        boundary(0, 0, 1, 0);
        dispatch("prio", 16'h0050, 5'h10);

        // EI delay
        do_reset();
        ie = 8'h01; pc = 16'h0100;
        write_if(5'h01);
        boundary(1, 0, 0, 0);
        chk("ei_ime0", ime, 1'b0);
        boundary(0, 0, 0, 0);
        chk("ei_nodsp", dsp_active, 1'b0);
        chk("ei_ime1", ime, 1'b1);
        dispatch("ei", 16'h0040, 5'h00);

        // DI cancels a pending EI
        boundary(1, 0, 0, 0);
        boundary(0, 1, 0, 0);
        boundary(0, 0, 0, 0);
        chk("di_cancel", ime, 1'b0);

        // irq set wins over IF write clear
        irq_in = 5'h02; if_we = 1'b1; if_wdata = 5'h00;
        tick(); quiet();
        chk("set_wins", if_rdata, 8'hE2);

        // mcyc low holds state
        mcyc = 1'b0; irq_in = 5'h08; tick(); quiet(); mcyc = 1'b1;
        chk("mcyc_hold", if_rdata, 8'hE2);

        // halt wake without dispatch
        do_reset();
        ie = 8'h04;
        boundary(0, 0, 0, 1);
        chk("halt_set", halted, 1'b1);
        tick();
        chk("halt_stay", halted, 1'b1);
        irq_in = 5'h04; tick(); quiet();
        p = 0;
        while (halted && p < 4) begin p++; tick(); end
        chk("halt_wake", halted, 1'b0);
        chk("halt_nodsp", dsp_active, 1'b0);
        chk("halt_if", if_rdata, 8'hE4);

        // halt with pending and ime=0
        do_reset();
        ie = 8'h01;
        write_if(5'h01);
`ifdef SM83_HALT_BUG_EN
        exp_hb = 1'b1;
`else
        exp_hb = 1'b0;
`endif
        boundary(0, 0, 0, 1);
        chk("hbug_pulse", halt_bug, exp_hb);
        chk("hbug_nohalt", halted, 1'b0);
        tick();
        chk("hbug_end", halt_bug, 1'b0);

        // reset during PUSH_HI
        do_reset();
        ie = 8'h01; pc = 16'hA55A;
        write_if(5'h01);
        boundary(0, 0, 1, 0);
        instr_done = 1'b1; tick(); quiet();
        p = 0;
        while (!bus_wr && p < 6) begin p++; tick(); end
        chk("rst_mid_pushhi", {bus_wr, bus_wdata}, {1'b1, 8'hA5});
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rstm_dsp", dsp_active, 1'b0);
        chk("rstm_wr", bus_wr, 1'b0);
        chk("rstm_ime", ime, 1'b0);
        chk("rstm_if", if_rdata, 8'hE0);
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_wr) p++;
            tick();
        end
        chk("rstm_nowr", p, 0);

        // random IF traffic, nothing enabled
        do_reset();
        ie = 8'h00; m_if = 5'h00;
        for (int i = 0; i < 40; i++) begin
            irq_in = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
            if_we = ($urandom_range(0, 2) == 0);
            if_wdata = 5'($urandom);
            m_if = (if_we ? if_wdata : m_if) | irq_in;
            tick();
            chk("rnd_if", if_rdata, {3'b111, m_if});
        end
        quiet();

        // random dispatch scenarios
        for (int i = 0; i < 20; i++) begin
            boundary(0, 1, 0, 0);
            ie = 8'($urandom);
            w = 5'($urandom);
            pc = 16'($urandom);
            write_if(w);
            boundary(0, 0, 1, 0);
            p = int'(ie[4:0] & w);
            if (p == 0) begin
                boundary(0, 0, 0, 0);
                chk("rnd_nodsp", dsp_active, 1'b0);
            end else begin
                low = 5'(p & -p);
                dispatch("rnd", 16'h0040 + 16'(8 * $clog2(int'(low))),
                         w & ~low);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sm83_int_ctl.md
SM83_INT_CTL -- requirements
Module: sm83_int_ctl

Interface
REQ-001 The module SHALL have one clock and synchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 synchronous active-low reset.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- mcyc  in  1  M-cycle strobe; all state advances only on clk edges where mcyc=1
- irq_in  in  5  peripheral request pulses {joypad,serial,timer,stat,vblank}; sets IF bits
- if_we  in  1  CPU write strobe to IF (FF0F)
- if_wdata  in  5  IF write data
- if_rdata  out  8  {3'b111, IF}
- ie  in  8  IE register value (bits 4:0 used)
- instr_done  in  1  core is at an instruction boundary this M-cycle
- ei_exec, di_exec, reti_exec, halt_exec  in  1 each  decoded CTL_EI/CTL_DI/CTL_RETI/CTL_HALT, valid with instr_done
- pc  in  16  current PC (r16_t)
- dsp_active  out  1  dispatch in progress; core stalls fetch
- addr_sel  out  3  addr_sel_t; SP during pushes, else NONE
- sp_dec  out  1  core decrements SP this M-cycle
- bus_wr, bus_wdata  out  1, 8  memory write strobe and data
- pc_load, pc_vec  out  1, 16  load PC with vector
- ime  out  1  master interrupt enable
- halted  out  1  core halted
- halt_bug  out  1  suppress next PC increment (see REQ-017)

Function
REQ-003 pending SHALL equal ie[4:0] & IF, combinational.
REQ-004 IF bit n SHALL be set on any mcyc where irq_in[n]=1; if_we loads if_wdata; set by irq_in SHALL win over clear by if_we or dispatch in the same cycle.
REQ-005 di_exec SHALL clear ime and ei_pend on the same mcyc; reti_exec SHALL set ime on the same mcyc.
REQ-006 ei_exec SHALL set ei_pend; the next instr_done with ei_pend=1 SHALL set ime and clear ei_pend (one-instruction delay).
REQ-007 The FSM SHALL have states IDLE, D_WAIT0, D_WAIT1, D_PUSH_HI, D_PUSH_LO, D_JUMP, each lasting exactly one mcyc.
REQ-008 IDLE->D_WAIT0 SHALL occur when instr_done && ime && pending!=0 (registered ime); on entry ime SHALL clear.
REQ-009 D_WAIT1: sp_dec=1. D_PUSH_HI: addr_sel=SP, bus_wr=1, bus_wdata=pc.msb, sp_dec=1. D_PUSH_LO: addr_sel=SP, bus_wr=1, bus_wdata=pc.lsb.
REQ-010 The priority index SHALL be sampled in D_PUSH_LO as the lowest set bit of pending; if pending=0 then, pc_vec SHALL be 16'h0000.
REQ-011 D_JUMP: pc_load=1, pc_vec=16'h0040+8*index, IF[index] cleared; next state IDLE.
REQ-012 dsp_active SHALL be 1 in every non-IDLE state; total dispatch latency SHALL be 5 M-cycles.
REQ-013 halt_exec with instr_done SHALL set halted unless REQ-017 applies.
REQ-014 halted SHALL clear on the first mcyc with pending!=0, regardless of ime; if ime=1 dispatch SHALL start at the following boundary.
REQ-015 ei_exec, di_exec and reti_exec SHALL be ignored while dsp_active=1.

Reset
REQ-016 On rst_n=0 at clk: IF=0, ime=0, ei_pend=0, halted=0, state=IDLE, all strobes 0, addr_sel=NONE, bus_wdata=0, pc_vec=0; reset mid-dispatch SHALL abort with no further bus_wr.

Configuration
REQ-017 With SM83_HALT_BUG_EN defined, halt_exec when ime=0 and pending!=0 SHALL NOT halt and SHALL pulse halt_bug for one mcyc; without the macro, halt_bug SHALL be tied 0 and the same case SHALL NOT halt.

Structure
REQ-018 sm83_pkg SHALL gain int_state_t (FSM enum), int_src_t (5 sources) and INT_VEC_BASE=16'h0040.
REQ-019 The lowest-set-bit encoder SHALL be sub-module sm83_int_prio (5-bit in, 3-bit index and valid out).

Verification
REQ-020 ime=1, ie=0x01, irq_in=0x01 at boundary, pc=0x1234 -> writes 0x12 then 0x34, pc_vec=0x0040, IF=0x00, ime=0, 5 M-cycles.
REQ-021 ie=0x1F, IF=0x14 -> vector 0x0050, IF becomes 0x10.
REQ-022 EI then one instruction with IF&IE!=0 -> no dispatch at first boundary, dispatch at second.
REQ-023 halt with ime=0, pending=0, then irq_in=0x04, ie=0x04 -> halted falls, no dispatch, IF=0x04.
REQ-024 halt with ime=0, pending=0x01 -> halt_bug=1 for one mcyc with SM83_HALT_BUG_EN, 0 without; halted=0 both builds.
REQ-025 rst_n=0 during D_PUSH_HI -> next cycle IDLE, bus_wr=0, ime=0, IF=0.
